// File: rtl/concat_frame_scheduler_if.sv
// Stream bundle for concat_frame_scheduler: per-input word requests in,
// one tagged frame stream out towards the shared concatenator.
interface concat_frame_scheduler_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4
);
    localparam int SW = $clog2(NUM_INPUTS);

    logic [NUM_INPUTS*WIDTH-1:0] i_in_data;
    logic [NUM_INPUTS-1:0]       i_in_valid;
    logic [NUM_INPUTS-1:0]       o_in_ready;
    logic [WIDTH-1:0]            o_out_data;
    logic                        o_out_valid;
    logic                        o_out_last;
    logic [SW-1:0]               o_out_source;
    logic                        o_busy;
    logic                        o_timeout;

    modport slave (
        input  i_in_data,
        input  i_in_valid,
        output o_in_ready,
        output o_out_data,
        output o_out_valid,
        output o_out_last,
        output o_out_source,
        output o_busy,
        output o_timeout
    );

    modport master (
        output i_in_data,
        output i_in_valid,
        input  o_in_ready,
        input  o_out_data,
        input  o_out_valid,
        input  o_out_last,
        input  o_out_source,
        input  o_busy,
        input  o_timeout
    );
endinterface

// File: rtl/concat_frame_scheduler.sv
// Round-robin frame scheduler sharing one concatenator between inputs.
// Define CONCAT_FRAME_SCHEDULER_TIMEOUT_EN to zero-pad stalled frames.
module concat_frame_scheduler #(
    parameter int WIDTH          = 8,
    parameter int NUM_WORDS      = 1024,
    parameter int NUM_INPUTS     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    concat_frame_scheduler_if.slave  bus
);
    localparam int SW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(NUM_WORDS);

    if (NUM_WORDS < 2) begin : g_chk_words
        $error("NUM_WORDS must be at least 2");
    end
    if (NUM_INPUTS < 2) begin : g_chk_inputs
        $error("NUM_INPUTS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
        ,
        S_PAD  = 2'd2
`endif
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_grant;
    logic [SW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic [SW-1:0]   r_out_source;
    logic            r_busy;

    logic [SW-1:0]         w_next_grant;
    logic [SW-1:0]         w_idx;
    logic                  w_any_req;
    logic                  w_xfer;
    logic                  w_last_word;
    logic [WIDTH-1:0]      w_sel_data;
    logic [NUM_INPUTS-1:0] w_onehot;

`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_stall;
    logic          r_pad_first;
    logic          r_timeout;
`endif

    // First requester strictly after the pointer, wrapping around.
    always_comb begin
        w_any_req    = 1'b0;
        w_next_grant = r_ptr;
        w_idx        = r_ptr;
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            w_idx = SW'((int'(r_ptr) + i) % NUM_INPUTS);
            if (!w_any_req && bus.i_in_valid[w_idx]) begin
                w_any_req    = 1'b1;
                w_next_grant = w_idx;
            end
        end
    end

    assign w_onehot    = NUM_INPUTS'(1) << r_grant;
    assign w_xfer      = (r_state == S_XFER) && bus.i_in_valid[r_grant];
    assign w_last_word = (r_cnt == CW'(NUM_WORDS - 1));
    assign w_sel_data  = bus.i_in_data[int'(r_grant)*WIDTH +: WIDTH];

    assign bus.o_in_ready   = (r_state == S_XFER) ? w_onehot : '0;
    assign bus.o_out_data   = r_out_data;
    assign bus.o_out_valid  = r_out_valid;
    assign bus.o_out_last   = r_out_last;
    assign bus.o_out_source = r_out_source;
    assign bus.o_busy       = r_busy;
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
    assign bus.o_timeout    = r_timeout;
`else
    assign bus.o_timeout    = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_ptr        <= SW'(NUM_INPUTS - 1);
            r_cnt        <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_source <= '0;
            r_busy       <= 1'b0;
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
            r_stall      <= '0;
            r_pad_first  <= 1'b0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            unique case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_next_grant;
                        r_ptr   <= w_next_grant;
                        r_cnt   <= '0;
                        r_state <= S_XFER;
                        r_busy  <= 1'b1;
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
                        r_stall <= '0;
`endif
                    end
                end
                S_XFER: begin
                    if (w_xfer) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= w_sel_data;
                        r_out_source <= r_grant;
                        r_out_last   <= w_last_word;
                        r_cnt        <= r_cnt + CW'(1);
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
                        r_stall      <= '0;
`endif
                        if (w_last_word) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
                    else if (r_stall == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= S_PAD;
                        r_busy      <= 1'b0;
                        r_pad_first <= 1'b1;
                    end else begin
                        r_stall <= r_stall + TW'(1);
                    end
`endif
                end
`ifdef CONCAT_FRAME_SCHEDULER_TIMEOUT_EN
                // Fill the rest of the aborted frame with zero words.
                S_PAD: begin
                    r_out_valid  <= 1'b1;
                    r_out_data   <= '0;
                    r_out_source <= r_grant;
                    r_out_last   <= w_last_word;
                    r_timeout    <= r_pad_first;
                    r_pad_first  <= 1'b0;
                    r_cnt        <= r_cnt + CW'(1);
                    if (w_last_word) begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/concat_frame_scheduler.md
Name: concat_frame_scheduler

Overview:
- Round-robin scheduler that shares one concatenator datapath between NUM_INPUTS requesting streams.
- Grants one requester at a time and forwards exactly NUM_WORDS words from it as one frame, then re-arbitrates.
- Output is a valid-only stream (no backpressure) that feeds the concatenator directly; each frame carries last and source tags.

Parameters:
- WIDTH, 8, data word width in bits.
- NUM_WORDS, 1024, words per frame; legal range >= 2.
- NUM_INPUTS, 4, number of requesting streams; legal range >= 2.
- TIMEOUT_CYCLES, 256, stall limit in cycles; used only with the optional feature.
- Derived: SW = $clog2(NUM_INPUTS); CW = $clog2(NUM_WORDS).

Ports:
- i_clock  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_in_data  in  NUM_INPUTS*WIDTH  packed input words; input k occupies [k*WIDTH +: WIDTH].
- i_in_valid  in  NUM_INPUTS  per-input word valid; also acts as the frame request.
- o_in_ready  out  NUM_INPUTS  per-input ready; one-hot or zero.
- o_out_data  out  WIDTH  forwarded word (registered).
- o_out_valid  out  1  forwarded word valid (registered).
- o_out_last  out  1  high with the final (NUM_WORDS-th) word of a frame.
- o_out_source  out  SW  index of the input that sourced the current word.
- o_busy  out  1  high while the scheduler is in XFER.
- o_timeout  out  1  one-cycle pulse when a frame is aborted by timeout; tied 0 without the macro.

Behaviour:
- Reset: asynchronous assert, synchronous-release use assumed upstream.
  - All registered outputs go to 0: o_out_data, o_out_valid, o_out_last, o_out_source, o_busy, o_timeout.
  - o_in_ready = 0.
  - State = IDLE, word counter = 0, RR pointer = NUM_INPUTS-1, so input 0 has first priority.
- State IDLE:
  - o_in_ready = 0.
  - If any i_in_valid bit is set, select the first set bit searching from pointer+1 upward, wrapping modulo NUM_INPUTS.
  - Register grant = that index, pointer = grant, counter = 0, then go to XFER.
  - If no bit is set, stay in IDLE.
- State XFER:
  - o_in_ready = one-hot(grant), combinational from the state and grant registers only, never from i_in_valid.
  - Transfer occurs when i_in_valid[grant] & o_in_ready[grant].
  - On a transfer, the next cycle gives o_out_valid=1, o_out_data = that word, o_out_source = grant. Latency is 1 cycle.
  - On a cycle with no transfer, the next cycle gives o_out_valid=0. o_out_data holds its previous value.
  - counter increments per transfer. The transfer with counter == NUM_WORDS-1 produces o_out_last=1 on the next cycle and returns the state to IDLE.
- One bubble: after the last transfer the scheduler spends exactly one cycle in IDLE (ready=0) before the next grant. Minimum frame period is NUM_WORDS+1 cycles.
- Requests are sampled only in IDLE. Requesters that assert valid mid-frame wait. A granted frame is never preempted.
- Dropping i_in_valid[grant] mid-frame stalls the frame with no output. The frame resumes when valid returns.
- o_busy = 1 exactly while in XFER.
- Reset mid-frame: the frame is truncated with no o_out_last. The next frame after reset starts at counter 0 from input 0 if it is requesting.

Optional Feature:
- Macro: CONCAT_FRAME_SCHEDULER_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every transfer and on entry to XFER, and increments on each XFER cycle with no transfer.
  - When it reaches TIMEOUT_CYCLES, the state goes to PAD. o_in_ready = 0 in PAD.
  - PAD emits one zero word per cycle (o_out_valid=1, data=0, source=grant) until the frame totals NUM_WORDS words. The last pad word carries o_out_last=1.
  - o_timeout pulses for one cycle with the first pad word. The state then goes to IDLE.
- Not defined: no stall counter and no PAD state; o_timeout is constant 0. Stalls wait indefinitely.

Test Plan:
- Reset: i_reset_n=0 mid-XFER at word 10 -> all outputs 0 the same cycle. After release, input 0 requesting -> grant 0, o_in_ready=4'b0001 one cycle later.
- Single source: NUM_WORDS=4, input 2 streams 0xA0..0xA3 continuously -> o_out_valid for 4 cycles, data A0..A3, source=2, last only on A3, o_busy high for 4 cycles.
- Round robin: NUM_WORDS=4, all inputs always valid -> frame order 0,1,2,3,0. Exactly one idle cycle between frames. Every frame has 4 words.
- Stall: input 1 granted, valid dropped for 3 cycles after word 1 -> 3 output gaps, then words 2,3 arrive. last asserted on word 3; no data loss or duplication.
- Skip/wrap: pointer=1, only inputs 0 and 3 requesting -> grant 3 first, then 0.
- Timeout (macro on, TIMEOUT_CYCLES=8, NUM_WORDS=4): input 0 sends 1 word then stalls -> after 8 stalled cycles, 3 zero words are emitted. o_timeout pulses with the first pad word; last is set on the third.
